// File: rtl/seg16_pkg.sv
// Shared 16-segment encode table, sample type and character constants.
// Used by both the display driver and the scan decoder so both ends agree on one table.
package seg16_pkg;

  localparam logic [15:0] SEG16_BLANK        = 16'h0000;
  localparam logic [7:0]  SEG16_SPACE_CHAR   = 8'h20;
  localparam logic [7:0]  SEG16_UNKNOWN_CHAR = 8'h3F;

  // Bit order: a1 a2 b c d1 d2 e f g1 g2 h i j k l m (bit 0 = a1).
  // C/O and M/N deliberately share a glyph on this display.
  localparam logic [15:0] SEG16_A = 16'h03CF;
  localparam logic [15:0] SEG16_B = 16'h4A3F;
  localparam logic [15:0] SEG16_C = 16'h00F3;
  localparam logic [15:0] SEG16_D = 16'h483F;
  localparam logic [15:0] SEG16_E = 16'h01F3;
  localparam logic [15:0] SEG16_F = 16'h01C3;
  localparam logic [15:0] SEG16_G = 16'h02FB;
  localparam logic [15:0] SEG16_H = 16'h03CC;
  localparam logic [15:0] SEG16_I = 16'h4833;
  localparam logic [15:0] SEG16_J = 16'h007C;
  localparam logic [15:0] SEG16_K = 16'h31C0;
  localparam logic [15:0] SEG16_L = 16'h00F0;
  localparam logic [15:0] SEG16_M = 16'h14CC;
  localparam logic [15:0] SEG16_N = 16'h14CC;
  localparam logic [15:0] SEG16_O = 16'h00F3;
  localparam logic [15:0] SEG16_P = 16'h03C7;
  localparam logic [15:0] SEG16_Q = 16'h20FF;
  localparam logic [15:0] SEG16_R = 16'h23C7;
  localparam logic [15:0] SEG16_S = 16'h03BB;
  localparam logic [15:0] SEG16_T = 16'h4803;
  localparam logic [15:0] SEG16_U = 16'h00FC;
  localparam logic [15:0] SEG16_V = 16'h90C0;
  localparam logic [15:0] SEG16_W = 16'hA0CC;
  localparam logic [15:0] SEG16_X = 16'hB400;
  localparam logic [15:0] SEG16_Y = 16'h5400;
  localparam logic [15:0] SEG16_Z = 16'h9033;

  typedef struct packed {
    logic [2:0]  digit;
    logic [15:0] segments;
  } seg16_sample_t;

  // Characters without a glyph render blank.
  function automatic logic [15:0] seg16_encode(input logic [7:0] ch);
    case (ch)
      8'h41:   return SEG16_A;
      8'h42:   return SEG16_B;
      8'h43:   return SEG16_C;
      8'h44:   return SEG16_D;
      8'h45:   return SEG16_E;
      8'h46:   return SEG16_F;
      8'h47:   return SEG16_G;
      8'h48:   return SEG16_H;
      8'h49:   return SEG16_I;
      8'h4A:   return SEG16_J;
      8'h4B:   return SEG16_K;
      8'h4C:   return SEG16_L;
      8'h4D:   return SEG16_M;
      8'h4E:   return SEG16_N;
      8'h4F:   return SEG16_O;
      8'h50:   return SEG16_P;
      8'h51:   return SEG16_Q;
      8'h52:   return SEG16_R;
      8'h53:   return SEG16_S;
      8'h54:   return SEG16_T;
      8'h55:   return SEG16_U;
      8'h56:   return SEG16_V;
      8'h57:   return SEG16_W;
      8'h58:   return SEG16_X;
      8'h59:   return SEG16_Y;
      8'h5A:   return SEG16_Z;
      default: return SEG16_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg16_pattern_decode.sv
// Combinational inverse of the 16-segment encode table; no state, no handshake.
// Blank maps to space, unmatched patterns map to '?' with unknown set.
module seg16_pattern_decode
  import seg16_pkg::*;
(
  input  logic [15:0] pattern,
  output logic [7:0]  ascii,
  output logic        unknown
);

  // Scanning Z down to A lets the lowest code win on shared glyphs.
  always_comb begin
    ascii   = SEG16_UNKNOWN_CHAR;
    unknown = 1'b1;
    if (pattern == SEG16_BLANK) begin
      ascii   = SEG16_SPACE_CHAR;
      unknown = 1'b0;
    end else begin
      for (int c = 8'h5A; c >= 8'h41; c--) begin
        if (seg16_encode(8'(c)) == pattern) begin
          ascii   = 8'(c);
          unknown = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg16_scan_decoder.sv
// Recovers one ASCII character per settled digit dwell from the multiplexed display bus.
// Optional SEG16_DEC_FRAME_EN adds a 6-character frame buffer with a frame_done pulse.
module seg16_scan_decoder
  import seg16_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] segments,
  input  logic [2:0]  digit_sel,
  output logic [7:0]  char_out,
  output logic [2:0]  char_digit,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        unknown,
  output logic        overflow
`ifdef SEG16_DEC_FRAME_EN
  ,
  output logic [47:0] frame_chars,
  output logic        frame_done
`endif
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} out_state_t;

  seg16_sample_t sample;
  seg16_sample_t s_q;
  logic [CW-1:0] cnt;
  logic          same;
  logic          digit_ok;
  logic          emit;
  logic [7:0]    dec_char;
  logic          dec_unknown;

  out_state_t    state;
  out_state_t    state_d;
  logic          load;
  logic          drop;

  always_comb begin
    sample          = '0;
    sample.digit    = digit_sel;
    sample.segments = segments;
  end

  assign same     = (sample == s_q);
  assign digit_ok = (32'(s_q.digit) < NUM_DIGITS);
  // Fires once, on the edge the count reaches the threshold; saturation blocks repeats.
  assign emit     = same && (cnt == CNT_LAST) && digit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      cnt <= '0;
    end else if (!same) begin
      s_q <= sample;
      cnt <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  seg16_pattern_decode u_decode (
    .pattern (s_q.segments),
    .ascii   (dec_char),
    .unknown (dec_unknown)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    drop    = 1'b0;
    case (state)
      EMPTY: begin
        if (emit) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (char_ready) begin
          if (emit) load    = 1'b1;
          else      state_d = EMPTY;
        end else if (emit) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign char_valid = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_out   <= '0;
      char_digit <= '0;
      unknown    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        char_out   <= dec_char;
        char_digit <= s_q.digit;
        unknown    <= dec_unknown;
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef SEG16_DEC_FRAME_EN
  logic       frame_hit;
  logic [5:0] seen;
  logic [5:0] seen_nxt;

  // Frame capture ignores the stream handshake: every emit lands here.
  assign frame_hit = emit && (s_q.digit < 3'd6);
  assign seen_nxt  = frame_hit ? (seen | (6'b1 << s_q.digit)) : seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_chars <= {6{SEG16_SPACE_CHAR}};
      seen        <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_hit) begin
        frame_chars[{s_q.digit, 3'b000} +: 8] <= dec_char;
        if (seen_nxt == 6'h3F) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end
`endif

endmodule
